// File: rtl/serdes_rx_bringup_if.sv
// Lane-side signal bundle for the RX SERDES bring-up sequencer.
// The slave modport is the sequencer; the master modport is the lane controller/PLL side.
interface serdes_rx_bringup_if #(
  parameter int unsigned DATA_W = 8
);
  logic              PLL_LOCKED_I;
  logic [DATA_W-1:0] RX_DATA_I;
  logic              RESTART_I;
  logic              SERDES_RST_O;
  logic              BITSLIP_O;
  logic              ALIGNED_O;
  logic              ALIGN_FAIL_O;
  logic [2:0]        STATE_O;

  modport master (
    output PLL_LOCKED_I, RX_DATA_I, RESTART_I,
    input  SERDES_RST_O, BITSLIP_O, ALIGNED_O, ALIGN_FAIL_O, STATE_O
  );

  modport slave (
    input  PLL_LOCKED_I, RX_DATA_I, RESTART_I,
    output SERDES_RST_O, BITSLIP_O, ALIGNED_O, ALIGN_FAIL_O, STATE_O
  );
endinterface

// File: rtl/serdes_rx_bringup.sv
// RX SERDES lane bring-up: qualifies PLL lock, sequences the ISERDES reset, then
// bitslips until the parallel word matches the training pattern.
module serdes_rx_bringup #(
  parameter int unsigned       DATA_W          = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN   = 8'h5C,
  parameter int unsigned       LOCK_STABLE_CYC = 256,
  parameter int unsigned       RST_HOLD_CYC    = 16,
  parameter int unsigned       BITSLIP_WAIT    = 4,
  parameter int unsigned       MATCH_CNT       = 16
) (
  input  logic               CLK,
  input  logic               RST,
  serdes_rx_bringup_if.slave lane_io
);

  localparam int unsigned CntMax0 = (LOCK_STABLE_CYC > RST_HOLD_CYC) ? LOCK_STABLE_CYC
                                                                     : RST_HOLD_CYC;
  localparam int unsigned CntMax  = (CntMax0 > BITSLIP_WAIT) ? CntMax0 : BITSLIP_WAIT;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned SlipW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned MatchW  = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StStable    = 3'd1,
    StSerdesRst = 3'd2,
    StSlipWait  = 3'd3,
    StCheck     = 3'd4,
    StSlip      = 3'd5,
    StAligned   = 3'd6,
    StFail      = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SlipW-1:0]  slip_cnt_q, slip_cnt_d;
  logic [MatchW-1:0] match_cnt_q, match_cnt_d;
  logic              lock_meta_q, lock_s_q;
  logic              serdes_rst_q, bitslip_q, aligned_q, align_fail_q;
  logic              lock_s;

  // PLL_LOCKED_I is asynchronous to CLK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lane_io.PLL_LOCKED_I;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign lock_s = lock_s_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slip_cnt_d  = slip_cnt_q;
    match_cnt_d = match_cnt_q;

    if (state_q != StWaitLock && !lock_s) begin
      state_d     = StWaitLock;
      cnt_d       = '0;
      slip_cnt_d  = '0;
      match_cnt_d = '0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
            cnt_d   = '0;
          end
        end
        StStable: begin
          if (cnt_q == CntW'(LOCK_STABLE_CYC - 1)) begin
            state_d = StSerdesRst;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSerdesRst: begin
          if (cnt_q == CntW'(RST_HOLD_CYC - 1)) begin
            state_d    = StSlipWait;
            cnt_d      = '0;
            slip_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSlipWait: begin
          if (cnt_q == CntW'(BITSLIP_WAIT - 1)) begin
            state_d     = StCheck;
            cnt_d       = '0;
            match_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StCheck: begin
          if (lane_io.RX_DATA_I == TRAIN_PATTERN) begin
            if (match_cnt_q == MatchW'(MATCH_CNT - 1)) begin
              state_d = StAligned;
            end else begin
              match_cnt_d = match_cnt_q + MatchW'(1);
            end
          end else if (slip_cnt_q != SlipW'(DATA_W - 1)) begin
            state_d    = StSlip;
            slip_cnt_d = slip_cnt_q + SlipW'(1);
          end else begin
            state_d = StFail;
          end
        end
        StSlip: begin
          state_d = StSlipWait;
          cnt_d   = '0;
        end
        StAligned, StFail: begin
          if (lane_io.RESTART_I) begin
            state_d = StSerdesRst;
            cnt_d   = '0;
          end
        end
        default: state_d = StWaitLock;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with STATE_O.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StWaitLock;
      cnt_q        <= '0;
      slip_cnt_q   <= '0;
      match_cnt_q  <= '0;
      serdes_rst_q <= 1'b1;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      match_cnt_q  <= match_cnt_d;
      serdes_rst_q <= (state_d inside {StWaitLock, StStable, StSerdesRst});
      bitslip_q    <= (state_d == StSlip);
      aligned_q    <= (state_d == StAligned);
      align_fail_q <= (state_d == StFail);
    end
  end

  assign lane_io.SERDES_RST_O = serdes_rst_q;
  assign lane_io.BITSLIP_O    = bitslip_q;
  assign lane_io.ALIGNED_O    = aligned_q;
  assign lane_io.ALIGN_FAIL_O = align_fail_q;
  assign lane_io.STATE_O      = state_q;

endmodule

// File: tb/tb_serdes_rx_bringup.sv
// Directed bench for serdes_rx_bringup: lock qualification, reset hold, bitslip alignment,
// failure, restart, lock loss/glitch and mid-slip reset.
module tb_serdes_rx_bringup;

  localparam logic [7:0] Train = 8'h5C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serdes_rx_bringup_if #(.DATA_W(8)) bus ();

  serdes_rx_bringup #(
    .DATA_W          (8),
    .TRAIN_PATTERN   (Train),
    .LOCK_STABLE_CYC (256),
    .RST_HOLD_CYC    (16),
    .BITSLIP_WAIT    (4),
    .MATCH_CNT       (16)
  ) u_dut (
    .CLK     (clk),
    .RST     (rst),
    .lane_io (bus)
  );

  int n_checks;
  int n_pass;
  int total_slips;
  bit rot_en;
  int rot_off;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] w;
    w = {v, v} << k;
    return w[15:8];
  endfunction

  // Advance one cycle and sample 1 ns after the edge; models the ISERDES word shift.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.BITSLIP_O) begin
      total_slips++;
      if (rot_en) begin
        rot_off = (rot_off + 7) % 8;
        bus.RX_DATA_I = rotl8(Train, rot_off);
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.STATE_O != target && n < budget) begin
      cyc();
      n++;
    end
    check_eq(tag, 32'(bus.STATE_O), 32'(target));
  endtask

  task automatic measure_rst_high(output int n);
    n = 0;
    while (bus.SERDES_RST_O && n < 400) begin
      n++;
      cyc();
    end
  endtask

  task automatic run_align(output int pulses, output int bad_wait);
    int n;
    int w;
    n = 0;
    pulses = 0;
    bad_wait = 0;
    while (!bus.ALIGNED_O && !bus.ALIGN_FAIL_O && n < 300) begin
      if (bus.BITSLIP_O) begin
        pulses++;
        cyc();
        w = 0;
        while (bus.STATE_O == 3'd3 && w < 10) begin
          w++;
          cyc();
        end
        if (w != 4) bad_wait++;
      end else begin
        cyc();
      end
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.PLL_LOCKED_I = 1'b0;
    bus.RESTART_I = 1'b0;
    rot_en = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int bad_wait;
    n_checks = 0;
    n_pass = 0;
    total_slips = 0;
    rot_en = 1'b0;
    rot_off = 0;
    rst = 1'b1;
    bus.PLL_LOCKED_I = 1'b0;
    bus.RX_DATA_I = '0;
    bus.RESTART_I = 1'b0;
    repeat (3) cyc();

    check_eq("rst_state", 32'(bus.STATE_O), 0);
    check_eq("rst_serdes_rst", 32'(bus.SERDES_RST_O), 1);
    check_eq("rst_bitslip", 32'(bus.BITSLIP_O), 0);
    check_eq("rst_aligned", 32'(bus.ALIGNED_O), 0);
    check_eq("rst_fail", 32'(bus.ALIGN_FAIL_O), 0);
    rst = 1'b0;
    repeat (3) cyc();
    check_eq("idle_no_lock", 32'(bus.STATE_O), 0);

    // Aligned from start
    bus.RX_DATA_I = Train;
    bus.PLL_LOCKED_I = 1'b1;
    total_slips = 0;
    wait_state(3'd1, 10, "t1_stable");
    measure_rst_high(n);
    check_eq("t1_rst_hold", 32'(n), 272);
    check_eq("t1_slipwait_state", 32'(bus.STATE_O), 3);
    n = 0;
    while (bus.STATE_O == 3'd3 && n < 20) begin
      n++;
      cyc();
    end
    check_eq("t1_slipwait_len", 32'(n), 4);
    check_eq("t1_check_state", 32'(bus.STATE_O), 4);
    n = 0;
    while (!bus.ALIGNED_O && n < 100) begin
      n++;
      cyc();
    end
    check_eq("t1_check_len", 32'(n), 16);
    check_eq("t1_aligned_state", 32'(bus.STATE_O), 6);
    check_eq("t1_no_slips", 32'(total_slips), 0);
    bus.RX_DATA_I = 8'h00;
    repeat (5) cyc();
    check_eq("t1_data_ignored", 32'(bus.ALIGNED_O), 1);
    bus.RESTART_I = 1'b1;
    cyc();
    bus.RESTART_I = 1'b0;
    check_eq("t1_restart_state", 32'(bus.STATE_O), 2);
    check_eq("t1_restart_aligned", 32'(bus.ALIGNED_O), 0);
    check_eq("t1_restart_serdes_rst", 32'(bus.SERDES_RST_O), 1);

    // Rotated data, three positions off
    do_reset();
    rot_off = 3;
    bus.RX_DATA_I = rotl8(Train, 3);
    rot_en = 1'b1;
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd3, 400, "t2_slipwait");
    run_align(pulses, bad_wait);
    check_eq("t2_pulses", 32'(pulses), 3);
    check_eq("t2_bad_wait", 32'(bad_wait), 0);
    check_eq("t2_aligned", 32'(bus.ALIGNED_O), 1);
    check_eq("t2_state", 32'(bus.STATE_O), 6);
    rot_en = 1'b0;

    // No match ever
    do_reset();
    bus.RX_DATA_I = 8'h00;
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd3, 400, "t3_slipwait");
    run_align(pulses, bad_wait);
    check_eq("t3_pulses", 32'(pulses), 7);
    check_eq("t3_bad_wait", 32'(bad_wait), 0);
    check_eq("t3_state", 32'(bus.STATE_O), 7);
    check_eq("t3_fail", 32'(bus.ALIGN_FAIL_O), 1);
    check_eq("t3_aligned", 32'(bus.ALIGNED_O), 0);
    bus.RESTART_I = 1'b1;
    cyc();
    bus.RESTART_I = 1'b0;
    check_eq("t3_restart_state", 32'(bus.STATE_O), 2);
    check_eq("t3_restart_serdes_rst", 32'(bus.SERDES_RST_O), 1);
    check_eq("t3_restart_fail", 32'(bus.ALIGN_FAIL_O), 0);

    // Lock loss in CHECK after 10 matches
    do_reset();
    bus.RX_DATA_I = Train;
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd4, 400, "t4_check");
    repeat (10) cyc();
    check_eq("t4_still_check", 32'(bus.STATE_O), 4);
    bus.PLL_LOCKED_I = 1'b0;
    wait_state(3'd0, 3, "t4_lock_loss");
    check_eq("t4_serdes_rst", 32'(bus.SERDES_RST_O), 1);
    check_eq("t4_aligned", 32'(bus.ALIGNED_O), 0);
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd1, 6, "t4_relock");
    measure_rst_high(n);
    check_eq("t4_rst_hold", 32'(n), 272);

    // Lock glitch in STABLE at count 200
    do_reset();
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd1, 10, "t5_stable");
    repeat (200) cyc();
    check_eq("t5_still_stable", 32'(bus.STATE_O), 1);
    bus.PLL_LOCKED_I = 1'b0;
    repeat (2) cyc();
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd0, 5, "t5_glitch");
    check_eq("t5_serdes_rst", 32'(bus.SERDES_RST_O), 1);
    wait_state(3'd1, 6, "t5_restable");
    measure_rst_high(n);
    check_eq("t5_rst_hold", 32'(n), 272);

    // Reset while BITSLIP_O is high
    do_reset();
    bus.RX_DATA_I = 8'h00;
    bus.PLL_LOCKED_I = 1'b1;
    wait_state(3'd5, 400, "t6_slip");
    check_eq("t6_bitslip_high", 32'(bus.BITSLIP_O), 1);
    rst = 1'b1;
    cyc();
    check_eq("t6_bitslip", 32'(bus.BITSLIP_O), 0);
    check_eq("t6_state", 32'(bus.STATE_O), 0);
    check_eq("t6_serdes_rst", 32'(bus.SERDES_RST_O), 1);
    check_eq("t6_aligned", 32'(bus.ALIGNED_O), 0);
    check_eq("t6_fail", 32'(bus.ALIGN_FAIL_O), 0);
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serdes_rx_bringup.md
Name: serdes_rx_bringup

Overview:
- Bring-up sequencer for the receive SERDES lane. Runs in the divided clock domain produced by the lane PLL (its CLKOUT1, the /4 output), downstream of that PLL.
- Synchronises and qualifies the PLL lock output, then holds and releases the ISERDES reset.
- Performs word alignment: compares the deserialised parallel word against a fixed training pattern and issues BITSLIP pulses until it matches.
- Reports aligned or failed status to the lane controller.

Parameters:
- DATA_W, 8: parallel word width from the ISERDES.
- TRAIN_PATTERN, 8'h5C: expected training word (DATA_W bits).
- LOCK_STABLE_CYC, 256: number of consecutive synchronised-locked cycles required before the reset sequence starts.
- RST_HOLD_CYC, 16: number of cycles SERDES_RST_O is held in the SERDES_RST state.
- BITSLIP_WAIT, 4: settle cycles after the reset release and after each bitslip before comparing.
- MATCH_CNT, 16: number of consecutive matching words needed to declare alignment.

Ports:
- CLK  in  1  divided PLL clock (PLL CLKOUT1); all logic runs on its rising edge.
- RST  in  1  reset: synchronous, active-high.
- PLL_LOCKED_I  in  1  PLL LOCKED output; asynchronous to CLK.
- RX_DATA_I  in  DATA_W  parallel word from the ISERDES.
- RESTART_I  in  1  single-cycle pulse; restarts alignment from the ALIGNED or FAIL state.
- SERDES_RST_O  out  1  reset to the ISERDES/IDELAY, active-high.
- BITSLIP_O  out  1  one-cycle bitslip pulse to the ISERDES.
- ALIGNED_O  out  1  lane aligned.
- ALIGN_FAIL_O  out  1  alignment exhausted all bit positions.
- STATE_O  out  3  current FSM state encoding, for debug.

Behaviour:
- Lock synchroniser: PLL_LOCKED_I passes through a 2-FF synchroniser to give lock_s. Both FFs reset to 0.
- Reset values: state=WAIT_LOCK; SERDES_RST_O=1; BITSLIP_O=0; ALIGNED_O=0; ALIGN_FAIL_O=0; all counters 0. All outputs are registered.
- State encoding: WAIT_LOCK=0, STABLE=1, SERDES_RST=2, SLIP_WAIT=3, CHECK=4, SLIP=5, ALIGNED=6, FAIL=7.
- WAIT_LOCK: go to STABLE when lock_s=1; stable counter cleared.
- STABLE: count cycles with lock_s=1. After exactly LOCK_STABLE_CYC cycles in this state, go to SERDES_RST.
- SERDES_RST: stay exactly RST_HOLD_CYC cycles, then go to SLIP_WAIT with slip_cnt=0.
- SLIP_WAIT: stay exactly BITSLIP_WAIT cycles, then go to CHECK with match_cnt=0.
- CHECK, compare each cycle:
  - RX_DATA_I==TRAIN_PATTERN: match_cnt increments; on the MATCH_CNT-th consecutive match, the next state is ALIGNED.
  - Mismatch with slip_cnt<DATA_W-1: go to SLIP and increment slip_cnt.
  - Mismatch with slip_cnt==DATA_W-1: go to FAIL.
- SLIP: exactly one cycle, BITSLIP_O=1; then SLIP_WAIT. BITSLIP_O is never high for 2 consecutive cycles.
- ALIGNED: ALIGNED_O=1. RX_DATA_I is not monitored in this state. RESTART_I goes to SERDES_RST with ALIGNED_O=0.
- FAIL: ALIGN_FAIL_O=1. RESTART_I goes to SERDES_RST and clears ALIGN_FAIL_O.
- Output levels by state: SERDES_RST_O=1 in WAIT_LOCK, STABLE and SERDES_RST, 0 in all other states. ALIGNED_O and ALIGN_FAIL_O are high only in their own states.
- Lock loss: lock_s=0 in any state except WAIT_LOCK forces WAIT_LOCK on the next edge.
  - SERDES_RST_O=1, ALIGNED_O=0 and ALIGN_FAIL_O=0 from that edge.
  - A bitslip pulse in progress ends; all counters clear.
  - A lock glitch during STABLE restarts the stable count.
- Priority: RST > lock loss > RESTART_I > normal transitions. RESTART_I is ignored in states other than ALIGNED and FAIL.
- RST mid-operation: returns to the reset values on the same edge.
- The block relies on the PLL clock keeping toggling while LOCKED drops; no clock-stop detection.
- Counter widths are sized by $clog2 of their maximum count; no wrap-around is reachable.

Test Plan (defaults: DATA_W=8, pattern 8'h5C, 256/16/4/16):
- Aligned from start: raise PLL_LOCKED_I and drive RX_DATA_I=8'h5C constantly.
  - SERDES_RST_O stays 1 for 256+16 cycles after STATE_O first shows 1.
  - After 4 SLIP_WAIT cycles, ALIGNED_O rises 16 cycles after entering CHECK.
  - BITSLIP_O is never high.
- Rotated data: the bench model rotates the word per bitslip, starting 3 positions off.
  - Exactly 3 one-cycle BITSLIP_O pulses, each followed by 4 SLIP_WAIT cycles.
  - Then ALIGNED_O=1.
- No match: RX_DATA_I=8'h00 constantly.
  - Exactly 7 BITSLIP_O pulses, then STATE_O=7 and ALIGN_FAIL_O=1.
  - A RESTART_I pulse gives STATE_O=2, SERDES_RST_O=1 and ALIGN_FAIL_O=0 on the next cycle.
- Lock loss in CHECK after 10 matches: drop PLL_LOCKED_I.
  - Within 3 cycles: STATE_O=0, SERDES_RST_O=1, ALIGNED_O=0.
  - Re-lock repeats the full 256-cycle STABLE count.
- Lock glitch in STABLE: drop PLL_LOCKED_I for 2 cycles at count 200.
  - Returns to WAIT_LOCK; SERDES_RST_O is still 1 when the count restarts, and it deasserts only after a fresh 256+16.
- Reset mid-SLIP: assert RST in the cycle BITSLIP_O=1.
  - Next cycle: BITSLIP_O=0, STATE_O=0, SERDES_RST_O=1, all status outputs 0.
